baccarat_bank: RTL and testbench

Bankroll and wager ledger for the baccarat table, sitting directly downstream of the game sequencer. It captures the player's side-bet and stake when the sequencer pulses `load_wager`, escrows the stake from the balance, and settles the bet when the sequencer reports a nonzero `result`. It drives the balance and outcome indicators to the display stage.

---
 rtl/baccarat_bank.sv | 174 +++++++++++++++++
 tb/tb_baccarat_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/baccarat_bank.sv
// baccarat_bank: bankroll and wager ledger for the baccarat table.
// Captures a side bet and stake on load_wager, escrows the stake out of the
// balance, and settles it when the sequencer reports a nonzero result.
//
// Optional feature: define BACCARAT_BANK_COMMISSION_EN to take a floor 25%
// commission (stake>>2) off a winning banker payout.
//
// Ports:
//   slow_clock  clock, rising edge
//   resetb      asynchronous active-low reset
//   load_wager  sequencer strobe, samples bet_in / wager_amt
//   bet_in      side: 01 player, 10 banker, 11 tie, 00 no bet
//   wager_amt   requested stake
//   result      outcome: 00 none, 01 player, 10 banker, 11 tie
//   balance     bankroll excluding escrowed stake
//   stake       escrowed stake (0 when no bet active)
//   bet_active  stake in escrow
//   win/push/lose  one-cycle outcome pulses (SETTLE cycle)
//   broke       balance exhausted, held until reset
module baccarat_bank #(
  parameter int unsigned BAL_W     = 10,
  parameter int unsigned WAGER_W   = 4,
  parameter int unsigned START_BAL = 100
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic               load_wager,
  input  logic [1:0]         bet_in,
  input  logic [WAGER_W-1:0] wager_amt,
  input  logic [1:0]         result,
  output logic [BAL_W-1:0]   balance,
  output logic [WAGER_W-1:0] stake,
  output logic               bet_active,
  output logic               win,
  output logic               push,
  output logic               lose,
  output logic               broke
);

  localparam int unsigned PW = BAL_W + 1;  // payout width
  localparam int unsigned SW = BAL_W + 2;  // balance + payout sum width

  typedef enum logic [1:0] {StIdle, StLocked, StSettle, StBroke} state_e;

  state_e             state_q, state_d;
  logic [BAL_W-1:0]   balance_q, balance_d;
  logic [WAGER_W-1:0] stake_q, stake_d;
  logic [1:0]         side_q, side_d;
  logic               win_q, win_d, push_q, push_d, lose_q, lose_d;
  logic               bet_active_q, bet_active_d, broke_q, broke_d;

  logic [PW-1:0]      avail, wager_w, stake_w, payout, new_bal;
  logic [WAGER_W-1:0] eff;
  logic               capture_ok;
  logic [SW-1:0]      sum;
  logic [BAL_W-1:0]   settled_bal;

  // Funds the clamp is applied against: while LOCKED the old stake is
  // refunded in the same edge as a re-bet.
  always_comb begin
    wager_w = PW'(wager_amt);
    stake_w = PW'(stake_q);
    avail   = PW'(balance_q) + ((state_q == StLocked) ? stake_w : '0);
    eff     = (wager_w <= avail) ? wager_amt : avail[WAGER_W-1:0];
    capture_ok = load_wager && (bet_in != 2'b00) && (eff != '0);
    new_bal = avail - PW'(eff);
  end

  // Payout and pulse selection for the captured side against result.
  always_comb begin
    payout = '0;
    win_d  = 1'b0;
    push_d = 1'b0;
    lose_d = 1'b0;
    if (side_q == 2'b11 && result == 2'b11) begin
      payout = (stake_w << 3) + stake_w;
      win_d  = 1'b1;
    end else if (side_q != 2'b00 && side_q == result) begin
`ifdef BACCARAT_BANK_COMMISSION_EN
      payout = (side_q == 2'b10) ? (stake_w << 1) - (stake_w >> 2) : (stake_w << 1);
`else
      payout = stake_w << 1;
`endif
      win_d  = 1'b1;
    end else if (side_q != 2'b11 && side_q != 2'b00 && result == 2'b11) begin
      payout = stake_w;
      push_d = 1'b1;
    end else begin
      lose_d = 1'b1;
    end
    sum = SW'(balance_q) + SW'(payout);
    settled_bal = (sum[SW-1:BAL_W] != '0) ? '1 : sum[BAL_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    balance_d = balance_q;
    stake_d   = stake_q;
    side_d    = side_q;
    unique case (state_q)
      StIdle: begin
        if (capture_ok) begin
          stake_d   = eff;
          balance_d = new_bal[BAL_W-1:0];
          side_d    = bet_in;
          state_d   = StLocked;
        end
      end
      StLocked: begin
        if (result != 2'b00) begin
          // Settlement takes priority over a simultaneous strobe.
          balance_d = settled_bal;
          stake_d   = '0;
          state_d   = StSettle;
        end else if (load_wager) begin
          if (capture_ok) begin
            stake_d   = eff;
            balance_d = new_bal[BAL_W-1:0];
            side_d    = bet_in;
          end else begin
            stake_d   = '0;
            balance_d = avail[BAL_W-1:0];
            side_d    = 2'b00;
            state_d   = StIdle;
          end
        end
      end
      StSettle: begin
        side_d  = 2'b00;
        state_d = (balance_q == '0) ? StBroke : StIdle;
      end
      StBroke: begin
        state_d = StBroke;
      end
      default: state_d = StIdle;
    endcase
    bet_active_d = (state_d == StLocked);
    broke_d      = (state_d == StBroke);
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= StIdle;
      balance_q    <= BAL_W'(START_BAL);
      stake_q      <= '0;
      side_q       <= 2'b00;
      win_q        <= 1'b0;
      push_q       <= 1'b0;
      lose_q       <= 1'b0;
      bet_active_q <= 1'b0;
      broke_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      balance_q    <= balance_d;
      stake_q      <= stake_d;
      side_q       <= side_d;
      // Pulses only on the edge that enters SETTLE.
      win_q        <= win_d  && (state_d == StSettle) && (state_q == StLocked);
      push_q       <= push_d && (state_d == StSettle) && (state_q == StLocked);
      lose_q       <= lose_d && (state_d == StSettle) && (state_q == StLocked);
      bet_active_q <= bet_active_d;
      broke_q      <= broke_d;
    end
  end

  assign balance    = balance_q;
  assign stake      = stake_q;
  assign bet_active = bet_active_q;
  assign win        = win_q;
  assign push       = push_q;
  assign lose       = lose_q;
  assign broke      = broke_q;

endmodule

// File: tb/tb_baccarat_bank.sv
// Directed self-checking bench for baccarat_bank. A second instance with
// START_BAL=1000 shares the stimulus and is used for the saturation case.
module tb_baccarat_bank;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic       load_wager = 1'b0;
  logic [1:0] bet_in = 2'b00;
  logic [3:0] wager_amt = 4'd0;
  logic [1:0] result = 2'b00;

  logic [9:0] balance, balance_c;
  logic [3:0] stake, stake_c;
  logic       bet_active, win, push, lose, broke;
  logic       bet_active_c, win_c, push_c, lose_c, broke_c;

  int n_checks = 0;
  int n_pass = 0;

  always #5 slow_clock = ~slow_clock;

  baccarat_bank dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .load_wager (load_wager),
    .bet_in     (bet_in),
    .wager_amt  (wager_amt),
    .result     (result),
    .balance    (balance),
    .stake      (stake),
    .bet_active (bet_active),
    .win        (win),
    .push       (push),
    .lose       (lose),
    .broke      (broke)
  );

  baccarat_bank #(.START_BAL(1000)) dut_c (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .load_wager (load_wager),
    .bet_in     (bet_in),
    .wager_amt  (wager_amt),
    .result     (result),
    .balance    (balance_c),
    .stake      (stake_c),
    .bet_active (bet_active_c),
    .win        (win_c),
    .push       (push_c),
    .lose       (lose_c),
    .broke      (broke_c)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic cyc();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge slow_clock);
    resetb = 1'b0;
    #2;
    resetb = 1'b1;
    cyc();
  endtask

  task automatic play(input logic [1:0] b, input logic [3:0] a);
    load_wager = 1'b1;
    bet_in     = b;
    wager_amt  = a;
    cyc();
    load_wager = 1'b0;
    bet_in     = 2'b00;
    wager_amt  = 4'd0;
  endtask

  task automatic res(input logic [1:0] r);
    result = r;
    cyc();
    result = 2'b00;
  endtask

  initial begin
    do_reset();
    check("rst_balance", balance, 100);
    check("rst_stake", stake, 0);
    check("rst_flags", {bet_active, win, push, lose, broke}, 0);

    // Player bet wins 2x.
    play(2'b01, 4'd10);
    check("cap_balance", balance, 90);
    check("cap_stake", stake, 10);
    check("cap_active", bet_active, 1);
    cyc();
    res(2'b01);
    check("win_balance", balance, 110);
    check("win_pulse", {win, push, lose}, 3'b100);
    check("win_stake", stake, 0);
    cyc();
    check("win_pulse_gone", win, 0);
    check("win_idle", bet_active, 0);

    // Result in IDLE is ignored.
    res(2'b10);
    check("idle_res_pulse", {win, push, lose}, 0);
    check("idle_res_bal", balance, 110);

    // Tie bet wins 9x.
    do_reset();
    play(2'b11, 4'd5);
    check("tie_cap", balance, 95);
    res(2'b11);
    check("tie_win", balance, 140);
    check("tie_pulse", win, 1);

    // Banker bet pushes on tie.
    do_reset();
    play(2'b10, 4'd8);
    check("push_cap", balance, 92);
    res(2'b11);
    check("push_bal", balance, 100);
    check("push_pulse", {win, push, lose}, 3'b010);

    // Banker win, commission dependent.
    do_reset();
    play(2'b10, 4'd4);
    check("bank_cap", balance, 96);
    res(2'b10);
`ifdef BACCARAT_BANK_COMMISSION_EN
    check("bank_win", balance, 103);
`else
    check("bank_win", balance, 104);
`endif

    // Zero-stake and no-bet strobes do nothing.
    do_reset();
    play(2'b01, 4'd0);
    check("zero_amt_active", bet_active, 0);
    play(2'b00, 4'd9);
    check("no_bet_bal", balance, 100);

    // Re-bet while LOCKED refunds and re-captures; clamp against 100.
    play(2'b01, 4'd10);
    play(2'b10, 4'd15);
    check("rebet_bal", balance, 85);
    check("rebet_stake", stake, 15);
    play(2'b00, 4'd3);
    check("rebet_cancel_bal", balance, 100);
    check("rebet_cancel_act", bet_active, 0);

    // Simultaneous strobe and result: settlement only.
    play(2'b01, 4'd6);
    check("sim_cap", balance, 94);
    load_wager = 1'b1;
    bet_in = 2'b10;
    wager_amt = 4'd9;
    result = 2'b01;
    cyc();
    load_wager = 1'b0;
    result = 2'b00;
    check("sim_bal", balance, 106);
    check("sim_stake", stake, 0);
    check("sim_active", bet_active, 0);
    cyc();
    check("sim_after", balance, 106);

    // Saturation on the START_BAL=1000 instance.
    do_reset();
    play(2'b11, 4'd15);
    check("sat_cap", balance_c, 985);
    res(2'b11);
    check("sat_bal", balance_c, 1023);
    check("sat_main", balance, 220);

    // Drain to 3, then clamp and go broke.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      play(2'b01, 4'd15);
      res(2'b10);
      cyc();
    end
    play(2'b01, 4'd7);
    res(2'b10);
    cyc();
    check("drain_bal", balance, 3);
    play(2'b01, 4'd15);
    check("clamp_stake", stake, 3);
    check("clamp_bal", balance, 0);
    res(2'b10);
    check("lose_pulse", {win, push, lose}, 3'b001);
    check("broke_not_yet", broke, 0);
    cyc();
    check("broke_set", broke, 1);
    play(2'b01, 4'd5);
    res(2'b01);
    check("broke_bal", balance, 0);
    check("broke_hold", {broke, bet_active}, 2'b10);

    // Asynchronous reset while LOCKED.
    do_reset();
    play(2'b01, 4'd7);
    check("async_pre", stake, 7);
    #2;
    resetb = 1'b0;
    #1;
    check("async_bal", balance, 100);
    check("async_stake", stake, 0);
    check("async_flags", {bet_active, win, push, lose, broke}, 0);
    resetb = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
